// File: rtl/construtor_caminho_pkg.sv
// Shared definitions for the path-finding blocks: state encoding and default widths.
package construtor_caminho_pkg;

    localparam int ADDR_WIDTH_DEF  = 10;
    localparam int COUNT_WIDTH_DEF = 11;

    typedef enum logic [2:0] {
        OCIOSO  = 3'd0,
        EMITIR  = 3'd1,
        LER     = 3'd2,
        ESPERAR = 3'd3,
        FIM     = 3'd4
    } estado_t;

endpackage

// File: rtl/construtor_caminho.sv
// Walks the predecessor memory from destino back to fonte and streams each node
// on a valid/ready interface, reporting length, completion and loop errors.
module construtor_caminho
    import construtor_caminho_pkg::*;
#(
    parameter int ADDR_WIDTH  = ADDR_WIDTH_DEF,
    parameter int MAX_PASSOS  = 1024,
    parameter int COUNT_WIDTH = COUNT_WIDTH_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   construir_in,
    input  logic [ADDR_WIDTH-1:0]  fonte_in,
    input  logic [ADDR_WIDTH-1:0]  destino_in,
    output logic                   mem_rd_en_out,
    output logic [ADDR_WIDTH-1:0]  mem_rd_addr_out,
    input  logic [ADDR_WIDTH-1:0]  mem_rd_data_in,
    output logic                   caminho_valid_out,
    input  logic                   caminho_ready_in,
    output logic [ADDR_WIDTH-1:0]  caminho_addr_out,
    output logic                   caminho_last_out,
    output logic                   caminho_pronto_out,
    output logic                   caminho_erro_out,
    output logic [COUNT_WIDTH-1:0] caminho_comprimento_out,
    output logic                   ocupado_out
);

    localparam logic [COUNT_WIDTH-1:0] MAX_C = COUNT_WIDTH'(MAX_PASSOS);

    estado_t                 r_estado;
    estado_t                 w_estado_prox;
    logic [ADDR_WIDTH-1:0]   r_atual;
    logic [ADDR_WIDTH-1:0]   r_fonte;
    logic [COUNT_WIDTH-1:0]  r_contador;
    logic                    r_erro;
    logic [COUNT_WIDTH-1:0]  w_contador_inc;
    logic                    w_ultimo;
    logic                    w_handshake;

    assign w_contador_inc = r_contador + 1'b1;
    assign w_ultimo       = (r_atual == r_fonte);
    assign w_handshake    = (r_estado == EMITIR) && caminho_ready_in;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_estado <= OCIOSO;
        end else begin
            r_estado <= w_estado_prox;
        end
    end

    always_comb begin
        w_estado_prox           = r_estado;
        mem_rd_en_out           = 1'b0;
        mem_rd_addr_out         = '0;
        caminho_valid_out       = 1'b0;
        caminho_addr_out        = '0;
        caminho_last_out        = 1'b0;
        caminho_pronto_out      = 1'b0;
        case (r_estado)
            OCIOSO: begin
                if (construir_in) w_estado_prox = EMITIR;
            end
            EMITIR: begin
                caminho_valid_out = 1'b1;
                caminho_addr_out  = r_atual;
                caminho_last_out  = w_ultimo;
                if (caminho_ready_in) begin
                    if (w_ultimo || (w_contador_inc == MAX_C)) w_estado_prox = FIM;
                    else                                       w_estado_prox = LER;
                end
            end
            LER: begin
                mem_rd_en_out   = 1'b1;
                mem_rd_addr_out = r_atual;
                w_estado_prox   = ESPERAR;
            end
            ESPERAR: begin
                w_estado_prox = EMITIR;
            end
            FIM: begin
                caminho_pronto_out = 1'b1;
                w_estado_prox      = OCIOSO;
            end
            default: begin
                w_estado_prox = OCIOSO;
            end
        endcase
    end

    // Datapath registers; the last beat takes priority over the step limit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_atual    <= '0;
            r_fonte    <= '0;
            r_contador <= '0;
            r_erro     <= 1'b0;
        end else begin
            if (r_estado == OCIOSO && construir_in) begin
                r_atual    <= destino_in;
                r_fonte    <= fonte_in;
                r_contador <= '0;
                r_erro     <= 1'b0;
            end
            if (w_handshake) begin
                r_contador <= w_contador_inc;
                if (!w_ultimo && (w_contador_inc == MAX_C)) r_erro <= 1'b1;
            end
            if (r_estado == ESPERAR) begin
                r_atual <= mem_rd_data_in;
            end
        end
    end

    assign caminho_erro_out        = r_erro;
    assign caminho_comprimento_out = r_contador;
    assign ocupado_out             = (r_estado != OCIOSO);

endmodule

// File: tb/tb_construtor_caminho.sv
// Self-checking bench: predecessor-memory model plus a path-walk reference model.
module tb_construtor_caminho;

    localparam int AW = 10;
    localparam int CW = 11;
    localparam int MP = 8;

    logic          clk;
    logic          rst_n;
    logic          construir_in;
    logic [AW-1:0] fonte_in;
    logic [AW-1:0] destino_in;
    logic          mem_rd_en_out;
    logic [AW-1:0] mem_rd_addr_out;
    logic [AW-1:0] mem_rd_data_in;
    logic          caminho_valid_out;
    logic          caminho_ready_in;
    logic [AW-1:0] caminho_addr_out;
    logic          caminho_last_out;
    logic          caminho_pronto_out;
    logic          caminho_erro_out;
    logic [CW-1:0] caminho_comprimento_out;
    logic          ocupado_out;

    construtor_caminho #(
        .ADDR_WIDTH (AW),
        .MAX_PASSOS (MP),
        .COUNT_WIDTH(CW)
    ) dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .construir_in           (construir_in),
        .fonte_in               (fonte_in),
        .destino_in             (destino_in),
        .mem_rd_en_out          (mem_rd_en_out),
        .mem_rd_addr_out        (mem_rd_addr_out),
        .mem_rd_data_in         (mem_rd_data_in),
        .caminho_valid_out      (caminho_valid_out),
        .caminho_ready_in       (caminho_ready_in),
        .caminho_addr_out       (caminho_addr_out),
        .caminho_last_out       (caminho_last_out),
        .caminho_pronto_out     (caminho_pronto_out),
        .caminho_erro_out       (caminho_erro_out),
        .caminho_comprimento_out(caminho_comprimento_out),
        .ocupado_out            (ocupado_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    logic [AW-1:0] anterior [1024];
    initial mem_rd_data_in = '0;
    always @(posedge clk) begin
        if (mem_rd_en_out) mem_rd_data_in <= anterior[mem_rd_addr_out];
    end

    // Ready generator: 0 = always high, 1 = random, 2 = hold low 4 cycles per beat.
    int ready_mode = 0;
    int stall      = 0;
    initial caminho_ready_in = 1'b1;
    always @(posedge clk) begin
        #1;
        if (ready_mode == 0) begin
            caminho_ready_in = 1'b1;
        end else if (ready_mode == 1) begin
            caminho_ready_in = 1'($urandom_range(0, 1));
        end else if (caminho_valid_out && stall < 4) begin
            caminho_ready_in = 1'b0;
            stall++;
        end else begin
            caminho_ready_in = 1'b1;
            stall = 0;
        end
    end

    logic [AW-1:0] q_beat [$];
    logic          q_last [$];
    logic [AW-1:0] q_rd   [$];
    int            q_t    [$];
    int            n_pronto = 0;
    int            ciclo    = 0;
    logic          p_valid  = 1'b0;
    logic          p_ready  = 1'b0;
    logic [AW-1:0] p_addr   = '0;

    always @(negedge clk) begin
        ciclo++;
        if (p_valid && !p_ready && rst_n) begin
            n_cmp++;
            if (caminho_valid_out !== 1'b1 || caminho_addr_out !== p_addr) begin
                n_err++;
                $display("FAIL stable: valid=%0b addr=%0d required valid=1 addr=%0d",
                         caminho_valid_out, caminho_addr_out, p_addr);
            end
        end
        if (!caminho_valid_out && (caminho_addr_out !== '0 || caminho_last_out !== 1'b0)) begin
            n_cmp++;
            n_err++;
            $display("FAIL idle_addr: addr=%0d last=%0b required 0 0",
                     caminho_addr_out, caminho_last_out);
        end
        if (!mem_rd_en_out && mem_rd_addr_out !== '0) begin
            n_cmp++;
            n_err++;
            $display("FAIL idle_rd_addr: addr=%0d required 0", mem_rd_addr_out);
        end
        if (caminho_valid_out && caminho_ready_in) begin
            q_beat.push_back(caminho_addr_out);
            q_last.push_back(caminho_last_out);
            q_t.push_back(ciclo);
        end
        if (mem_rd_en_out) q_rd.push_back(mem_rd_addr_out);
        if (caminho_pronto_out) n_pronto++;
        p_valid = caminho_valid_out;
        p_ready = caminho_ready_in;
        p_addr  = caminho_addr_out;
    end

    task automatic set_path(input int nodes []);
        for (int i = 0; i + 1 < nodes.size(); i++) anterior[nodes[i]] = AW'(nodes[i+1]);
    endtask

    task automatic run_walk(input logic [AW-1:0] f, input logic [AW-1:0] d,
                            input int mode, input bit reenter, input string nome);
        logic [AW-1:0] exp_b [$];
        logic [AW-1:0] node;
        bit            exp_err;
        int            budget;
        node    = d;
        exp_err = 1'b1;
        for (int k = 0; k < MP; k++) begin
            exp_b.push_back(node);
            if (node == f) begin
                exp_err = 1'b0;
                break;
            end
            node = anterior[node];
        end

        ready_mode = mode;
        @(negedge clk);
        q_beat.delete(); q_last.delete(); q_rd.delete(); q_t.delete();
        n_pronto     = 0;
        fonte_in     = f;
        destino_in   = d;
        construir_in = 1'b1;
        @(negedge clk);
        construir_in = 1'b0;
        n_cmp++;
        if (caminho_valid_out !== 1'b1 || ocupado_out !== 1'b1) begin
            n_err++;
            $display("FAIL %s first_valid: valid=%0b busy=%0b required 1 1",
                     nome, caminho_valid_out, ocupado_out);
        end
        if (reenter) begin
            repeat (4) @(negedge clk);
            destino_in   = 2;
            fonte_in     = 2;
            construir_in = 1'b1;
            @(negedge clk);
            construir_in = 1'b0;
        end
        budget = 0;
        while (n_pronto == 0 && budget < 400) begin
            @(negedge clk);
            budget++;
        end
        repeat (3) @(negedge clk);

        n_cmp++;
        if (n_pronto != 1) begin
            n_err++;
            $display("FAIL %s pronto_count: got=%0d required=1", nome, n_pronto);
        end
        n_cmp++;
        if (q_beat.size() != exp_b.size()) begin
            n_err++;
            $display("FAIL %s beat_count: got=%0d required=%0d", nome, q_beat.size(), exp_b.size());
        end else begin
            for (int i = 0; i < exp_b.size(); i++) begin
                n_cmp++;
                if (q_beat[i] !== exp_b[i] ||
                    q_last[i] !== ((i == exp_b.size() - 1) && !exp_err)) begin
                    n_err++;
                    $display("FAIL %s beat[%0d]: addr=%0d last=%0b required addr=%0d last=%0b",
                             nome, i, q_beat[i], q_last[i], exp_b[i],
                             (i == exp_b.size() - 1) && !exp_err);
                end
            end
        end
        n_cmp++;
        if (q_rd.size() != exp_b.size() - 1) begin
            n_err++;
            $display("FAIL %s read_count: got=%0d required=%0d", nome, q_rd.size(), exp_b.size() - 1);
        end else begin
            for (int i = 0; i < q_rd.size(); i++) begin
                n_cmp++;
                if (q_rd[i] !== exp_b[i]) begin
                    n_err++;
                    $display("FAIL %s read[%0d]: got=%0d required=%0d", nome, i, q_rd[i], exp_b[i]);
                end
            end
        end
        if (mode == 0) begin
            for (int i = 1; i < q_t.size(); i++) begin
                n_cmp++;
                if (q_t[i] - q_t[i-1] != 3) begin
                    n_err++;
                    $display("FAIL %s spacing[%0d]: got=%0d required=3", nome, i, q_t[i] - q_t[i-1]);
                end
            end
        end
        n_cmp++;
        if (caminho_comprimento_out !== CW'(exp_b.size()) || caminho_erro_out !== exp_err ||
            ocupado_out !== 1'b0) begin
            n_err++;
            $display("FAIL %s final: len=%0d erro=%0b busy=%0b required len=%0d erro=%0b busy=0",
                     nome, caminho_comprimento_out, caminho_erro_out, ocupado_out,
                     exp_b.size(), exp_err);
        end
    endtask

    task automatic test_reset();
        rst_n        = 1'b0;
        construir_in = 1'b0;
        fonte_in     = '0;
        destino_in   = '0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({mem_rd_en_out, mem_rd_addr_out, caminho_valid_out, caminho_addr_out,
             caminho_last_out, caminho_pronto_out, caminho_erro_out,
             caminho_comprimento_out, ocupado_out} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: some output nonzero (len=%0d busy=%0b valid=%0b)",
                     caminho_comprimento_out, ocupado_out, caminho_valid_out);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic();
        set_path('{5, 3, 1, 0});
        run_walk(0, 5, 0, 1'b0, "basic");
    endtask

    task automatic test_single();
        run_walk(7, 7, 0, 1'b0, "single");
    endtask

    task automatic test_stall();
        set_path('{5, 3, 1, 0});
        run_walk(0, 5, 2, 1'b0, "stall");
    endtask

    task automatic test_loop();
        anterior[9] = 9;
        run_walk(0, 9, 0, 1'b0, "loop");
    endtask

    task automatic test_reenter();
        set_path('{5, 3, 1, 0});
        run_walk(0, 5, 0, 1'b1, "reenter");
    endtask

    task automatic test_reset_mid();
        int budget;
        set_path('{5, 3, 1, 0});
        ready_mode = 0;
        @(negedge clk);
        fonte_in     = 0;
        destino_in   = 5;
        construir_in = 1'b1;
        @(negedge clk);
        construir_in = 1'b0;
        budget = 0;
        while (mem_rd_en_out !== 1'b1 && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        @(negedge clk);
        n_pronto = 0;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({mem_rd_en_out, mem_rd_addr_out, caminho_valid_out, caminho_addr_out,
             caminho_last_out, caminho_pronto_out, caminho_erro_out,
             caminho_comprimento_out, ocupado_out} !== '0 || budget >= 20) begin
            n_err++;
            $display("FAIL reset_mid: len=%0d busy=%0b valid=%0b budget=%0d required all 0",
                     caminho_comprimento_out, ocupado_out, caminho_valid_out, budget);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        n_cmp++;
        if (n_pronto != 0 || ocupado_out !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid_quiet: pronto=%0d busy=%0b required 0 0", n_pronto, ocupado_out);
        end
        run_walk(0, 5, 0, 1'b0, "after_reset");
    endtask

    task automatic test_random();
        for (int t = 0; t < 8; t++) begin
            int len;
            int base;
            int step;
            int nodes [];
            len   = $urandom_range(1, 10);
            base  = $urandom_range(0, 1023);
            step  = 2 * $urandom_range(1, 200) + 1;
            nodes = new[len];
            for (int i = 0; i < len; i++) nodes[i] = (base + i * step) % 1024;
            set_path(nodes);
            run_walk(AW'(nodes[len-1]), AW'(nodes[0]), $urandom_range(0, 1), 1'b0, "random");
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) anterior[i] = AW'($urandom_range(0, 1023));
        test_reset();
        test_basic();
        test_single();
        test_stall();
        test_loop();
        test_reenter();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
